multiplier_pipeline: RTL

Pipelined RV32M multiplier, the companion arithmetic unit to the pipelined divider in the execute stage.
Accepts one MUL/MULH/MULHSU/MULHU operation per cycle and returns a 32-bit result with a fixed latency.
Carries a destination tag so writeback can match results to instructions.
Provides flush so the core can kill in-flight operations on a branch mispredict or trap.

---
 rtl/multiplier_pipeline_if.sv | 21 ++
 rtl/multiplier_pipeline.sv | 79 +++++++
 2 files changed

// File: rtl/multiplier_pipeline_if.sv
// multiplier_pipeline_if: issue/result bundle between the execute stage and the multiplier
interface multiplier_pipeline_if #(parameter int TAG_W = 5);
  logic             i_valid;
  logic [1:0]       i_op;
  logic [31:0]      i_rs1;
  logic [31:0]      i_rs2;
  logic [TAG_W-1:0] i_tag;
  logic             i_flush;
  logic             o_valid;
  logic [31:0]      o_result;
  logic [TAG_W-1:0] o_tag;
  logic             o_busy;
  modport master (
    output i_valid, i_op, i_rs1, i_rs2, i_tag, i_flush,
    input  o_valid, o_result, o_tag, o_busy
  );
  modport slave (
    input  i_valid, i_op, i_rs1, i_rs2, i_tag, i_flush,
    output o_valid, o_result, o_tag, o_busy
  );
endinterface

// File: rtl/multiplier_pipeline.sv
// multiplier_pipeline: RV32M MUL/MULH/MULHSU/MULHU, STAGES-deep shift-and-add pipeline with tag and flush
module multiplier_pipeline #(
  parameter int STAGES = 4,
  parameter int TAG_W  = 5
) (
  input logic clk,
  input logic rst,
  multiplier_pipeline_if.slave bus
);
  localparam int W = 32 / STAGES;
  localparam int L = STAGES - 1;
  logic             v      [STAGES];
  logic [1:0]       op_r   [STAGES];
  logic [TAG_W-1:0] tag_r  [STAGES];
  logic [32:0]      a_r    [STAGES];
  logic [32:0]      m_r    [STAGES];
  logic [65:0]      acc_r  [STAGES];
  logic             v_in   [STAGES];
  logic [1:0]       op_in  [STAGES];
  logic [TAG_W-1:0] tag_in [STAGES];
  logic [32:0]      a_in   [STAGES];
  logic [32:0]      m_in   [STAGES];
  logic [65:0]      acc_in [STAGES];
  logic [65:0]      acc_n  [STAGES];
  logic [65:0]      a66;
  logic             busy;
  always_comb begin
    v_in[0]   = bus.i_valid;
    op_in[0]  = bus.i_op;
    tag_in[0] = bus.i_tag;
    a_in[0]   = {bus.i_rs1[31] & (bus.i_op[0] ^ bus.i_op[1]), bus.i_rs1};
    m_in[0]   = {bus.i_rs2[31] & (bus.i_op == 2'b01), bus.i_rs2};
    acc_in[0] = '0;
    for (int s = 1; s < STAGES; s++) begin
      v_in[s]   = v[s-1];
      op_in[s]  = op_r[s-1];
      tag_in[s] = tag_r[s-1];
      a_in[s]   = a_r[s-1];
      m_in[s]   = m_r[s-1];
      acc_in[s] = acc_r[s-1];
    end
    a66 = '0;
    // m_in is pre-shifted, so the current chunk is always its low W bits and the sign sits at bit W in the last stage
    for (int s = 0; s < STAGES; s++) begin
      a66      = {{33{a_in[s][32]}}, a_in[s]};
      acc_n[s] = acc_in[s] + ((a66 * 66'(m_in[s][W-1:0])) << (s * W))
               - ((s == L && m_in[s][W]) ? a66 << 32 : 66'd0);
    end
    busy = 1'b0;
    for (int s = 0; s < STAGES; s++) busy = busy | v[s];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < STAGES; s++) begin
        v[s]     <= 1'b0;
        op_r[s]  <= '0;
        tag_r[s] <= '0;
        a_r[s]   <= '0;
        m_r[s]   <= '0;
        acc_r[s] <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        v[s] <= v_in[s] & ~bus.i_flush;
        if (v_in[s] && !bus.i_flush) begin
          op_r[s]  <= op_in[s];
          tag_r[s] <= tag_in[s];
          a_r[s]   <= a_in[s];
          m_r[s]   <= m_in[s] >> W;
          acc_r[s] <= acc_n[s];
        end
      end
    end
  end
  assign bus.o_valid  = v[L];
  assign bus.o_tag    = tag_r[L];
  assign bus.o_result = (op_r[L] == 2'b00) ? acc_r[L][31:0] : acc_r[L][63:32];
  assign bus.o_busy   = busy;
endmodule
